// File: rtl/dct_pkg.sv
// Shared types and default latencies for the 8x8 2-D DCT pipeline sequencer.
package dct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
  } tag_t;

  localparam int TAG_W       = 4;
  localparam int LAT_DEF     = 18;
  localparam int TP1_OFS_DEF = 9;
  localparam int DC_OFS_DEF  = 10;

  function automatic logic is_row0(input tag_t t);
    return t.valid && (t.row == 3'd0);
  endfunction

endpackage

// File: rtl/dct_tag_pipe.sv
// Row-tag shift register with enable and fixed read taps (two mid taps plus the last stage).
module dct_tag_pipe #(
  parameter int DEPTH = 18,
  parameter int W     = 4,
  parameter int TAP_A = 8,
  parameter int TAP_B = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap_a,
  output logic [W-1:0] tap_b,
  output logic [W-1:0] tap_last
);

  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tap_a    = sr[TAP_A];
  assign tap_b    = sr[TAP_B];
  assign tap_last = sr[DEPTH-1];

endmodule

// File: rtl/dct_pipe_ctrl.sv
// Sequencer for the 1-D DCT / TP0 / DCT / TP1 pipeline: handshake, global advance, start pulses, row tags.
// Optional performance counters (stall_cnt, gap_cnt) are built when DCT_PIPE_CTRL_PERF_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no block row pending at input, pipeline empty
// ST_ACCEPT | mid-block (row_in != 0), or a new block starting while rows drain
// ST_FLUSH  | between blocks, rows still in flight, no input offered
module dct_pipe_ctrl
  import dct_pkg::*;
#(
  parameter int LAT     = LAT_DEF,
  parameter int TP1_OFS = TP1_OFS_DEF,
  parameter int DC_OFS  = DC_OFS_DEF,
  parameter int CNT_W   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       out_row,
  output logic             out_last,
  output logic             pipe_en,
  output logic             tp0_start,
  output logic             tp1_start,
  output logic             dc_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] blk_in_cnt,
  output logic [CNT_W-1:0] blk_out_cnt
`ifdef DCT_PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      gap_cnt
`endif
);

  localparam int IF_W = $clog2(LAT + 1);

  tag_t            tag_in;
  tag_t            tag_tp1;
  tag_t            tag_dc;
  tag_t            tag_out;
  logic [2:0]      row_in;
  logic [IF_W-1:0] inflight;
  logic            adv_ok;
  logic            stall;
  logic            step;
  logic            in_fire;
  state_t          st;

  dct_tag_pipe #(
    .DEPTH (LAT),
    .W     (TAG_W),
    .TAP_A (TP1_OFS - 1),
    .TAP_B (DC_OFS - 1)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .en       (step),
    .din      (tag_in),
    .tap_a    (tag_tp1),
    .tap_b    (tag_dc),
    .tap_last (tag_out)
  );

  // A mid-block gap freezes everything: the transpose memories need contiguous rows.
  always_comb begin
    adv_ok       = in_valid || (row_in == 3'd0);
    stall        = tag_out.valid && !out_ready;
    step         = !stall && adv_ok && (in_valid || (inflight != '0));
    in_ready     = !stall;
    in_fire      = in_valid && in_ready && step;
    tag_in.valid = in_fire;
    tag_in.row   = row_in;
    pipe_en      = step;
    out_valid    = tag_out.valid && adv_ok;
    out_row      = tag_out.row;
    out_last     = out_valid && (tag_out.row == 3'd7);
    tp0_start    = in_fire && (row_in == 3'd0);
    tp1_start    = step && is_row0(tag_tp1);
    dc_sel       = step && is_row0(tag_dc);
  end

  always_comb begin
    st = ST_IDLE;
    if (row_in != 3'd0) begin
      st = ST_ACCEPT;
    end else if (inflight != '0) begin
      st = in_valid ? ST_ACCEPT : ST_FLUSH;
    end
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_in   <= 3'd0;
      inflight <= '0;
    end else if (step) begin
      if (in_fire) begin
        row_in <= row_in + 3'd1;
      end
      inflight <= inflight + IF_W'(in_fire) - IF_W'(tag_out.valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
    end else begin
      if (tp0_start) begin
        blk_in_cnt <= blk_in_cnt + CNT_W'(1);
      end
      if (out_valid && out_ready && out_last) begin
        blk_out_cnt <= blk_out_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DCT_PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      gap_cnt   <= 16'd0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if ((st == ST_ACCEPT) && !in_valid && (gap_cnt != 16'hFFFF)) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
